// File: rtl/cordic_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_scheduler
//
// Round-robin front end that time-shares one free-running, non-stallable
// pipelined CORDIC rotator between N_CH requesters. One request per cycle is
// granted, registered onto the CORDIC inputs, and tagged with its channel ID.
// The tag rides a delay line matched to the CORDIC latency so every result
// comes back with the channel that issued it. The result path has no
// backpressure.
//
// Ports
//   i_clk, i_resetn            clock, async active-low reset
//   i_chEnable[N_CH]           per-channel enable (disabled => never granted)
//   i_reqValid[N_CH]           per-channel request valid
//   i_reqX/i_reqY              flattened N_CH x DATA_WIDTH request operands
//   i_reqAngle                 flattened N_CH x 32 unsigned phase
//   o_reqReady[N_CH]           one-hot/zero grant, combinational
//   o_cordicX/Y/Angle          registered CORDIC inputs (0 when idle)
//   i_cordicX/Y                CORDIC outputs
//   o_resValid/o_resCh         result strobe and channel ID
//   o_resX/o_resY              registered result (held between strobes)
//   o_inFlight                 accepted requests not yet returned
// ---------------------------------------------------------------------------
module cordic_scheduler #(
    parameter  int N_CH           = 4,
    parameter  int DATA_WIDTH     = 16,
    parameter  int CORDIC_LATENCY = 18,
    localparam int CH_BITS        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int ANGLE_WIDTH    = 32
) (
    input  logic                          i_clk,
    input  logic                          i_resetn,
    input  logic [N_CH-1:0]               i_chEnable,
    input  logic [N_CH-1:0]               i_reqValid,
    input  logic [N_CH*DATA_WIDTH-1:0]    i_reqX,
    input  logic [N_CH*DATA_WIDTH-1:0]    i_reqY,
    input  logic [N_CH*ANGLE_WIDTH-1:0]   i_reqAngle,
    output logic [N_CH-1:0]               o_reqReady,
    output logic [DATA_WIDTH-1:0]         o_cordicX,
    output logic [DATA_WIDTH-1:0]         o_cordicY,
    output logic [ANGLE_WIDTH-1:0]        o_cordicAngle,
    input  logic [DATA_WIDTH-1:0]         i_cordicX,
    input  logic [DATA_WIDTH-1:0]         i_cordicY,
    output logic                          o_resValid,
    output logic [CH_BITS-1:0]            o_resCh,
    output logic [DATA_WIDTH-1:0]         o_resX,
    output logic [DATA_WIDTH-1:0]         o_resY,
    output logic [6:0]                    o_inFlight
);

    localparam int L = CORDIC_LATENCY;

    // Per-channel views of the flattened request buses.
    logic [N_CH-1:0][DATA_WIDTH-1:0]  req_x, req_y;
    logic [N_CH-1:0][ANGLE_WIDTH-1:0] req_ang;

    assign req_x   = i_reqX;
    assign req_y   = i_reqY;
    assign req_ang = i_reqAngle;

    // (base + step) mod N_CH, for pointer scan and pointer advance.
    function automatic logic [CH_BITS-1:0] wrap_add(input logic [CH_BITS-1:0] base,
                                                    input int step);
        return CH_BITS'((int'(base) + step) % N_CH);
    endfunction

    logic [CH_BITS-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]    elig;
    logic [CH_BITS-1:0] cand;
    logic               grant_vld;
    logic [CH_BITS-1:0] grant_ch;

    logic [DATA_WIDTH-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [ANGLE_WIDTH-1:0] ca_q, ca_d;

    // Stage 0 travels alongside o_cordic*; stage L lines up with the
    // CORDIC output for that request.
    logic [L:0]              vld_pipe_q, vld_pipe_d;
    logic [L:0][CH_BITS-1:0] ch_pipe_q, ch_pipe_d;
    logic                    ret;

    logic                  res_vld_q, res_vld_d;
    logic [CH_BITS-1:0]    res_ch_q, res_ch_d;
    logic [DATA_WIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
    logic [6:0]            inflight_q, inflight_d;

    assign elig = i_reqValid & i_chEnable;

    // First eligible channel scanning from ptr upward, wrapping.
    always_comb begin
        grant_vld  = 1'b0;
        grant_ch   = '0;
        cand       = '0;
        o_reqReady = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = wrap_add(ptr_q, i);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
        if (grant_vld) o_reqReady[grant_ch] = 1'b1;
    end

    assign ret = vld_pipe_q[L];

    always_comb begin
        ptr_d      = grant_vld ? wrap_add(grant_ch, 1) : ptr_q;
        cx_d       = grant_vld ? req_x[grant_ch]   : '0;
        cy_d       = grant_vld ? req_y[grant_ch]   : '0;
        ca_d       = grant_vld ? req_ang[grant_ch] : '0;
        vld_pipe_d = {vld_pipe_q[L-1:0], grant_vld};
        ch_pipe_d  = {ch_pipe_q[L-1:0], (grant_vld ? grant_ch : CH_BITS'(0))};
        res_vld_d  = ret;
        res_ch_d   = ch_pipe_q[L];
        res_x_d    = ret ? i_cordicX : res_x_q;
        res_y_d    = ret ? i_cordicY : res_y_q;
        // Decrement on the edge the result is captured, so a full pipe
        // reads CORDIC_LATENCY+1.
        case ({grant_vld, ret})
            2'b10:   inflight_d = inflight_q + 7'd1;
            2'b01:   inflight_d = inflight_q - 7'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ptr_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            ca_q       <= '0;
            vld_pipe_q <= '0;
            ch_pipe_q  <= '0;
            res_vld_q  <= 1'b0;
            res_ch_q   <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            ca_q       <= ca_d;
            vld_pipe_q <= vld_pipe_d;
            ch_pipe_q  <= ch_pipe_d;
            res_vld_q  <= res_vld_d;
            res_ch_q   <= res_ch_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_cordicX     = cx_q;
    assign o_cordicY     = cy_q;
    assign o_cordicAngle = ca_q;
    assign o_resValid    = res_vld_q;
    assign o_resCh       = res_ch_q;
    assign o_resX        = res_x_q;
    assign o_resY        = res_y_q;
    assign o_inFlight    = inflight_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_scheduler
//
// Directed bench for cordic_scheduler. The CORDIC is a plain delay line of
// depth CORDIC_LATENCY returning (x+1, y-1). A scoreboard of expected
// results (channel, x, y, accept cycle) is checked by a monitor on every
// o_resValid, including the accept-to-result distance of 19 edges.
// ---------------------------------------------------------------------------
module tb_cordic_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int L  = 18;
    localparam int CB = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         en, vld;
    logic [N-1:0][DW-1:0] rx, ry;
    logic [N-1:0][31:0]   ra;
    logic [N-1:0]         rdy;
    logic [DW-1:0]        cx, cy, ix, iy, resx, resy;
    logic [31:0]          ca;
    logic                 resv;
    logic [CB-1:0]        resch;
    logic [6:0]           infl;

    cordic_scheduler #(.N_CH(N), .DATA_WIDTH(DW), .CORDIC_LATENCY(L)) dut (
        .i_clk(clk), .i_resetn(rstn),
        .i_chEnable(en), .i_reqValid(vld),
        .i_reqX(rx), .i_reqY(ry), .i_reqAngle(ra),
        .o_reqReady(rdy),
        .o_cordicX(cx), .o_cordicY(cy), .o_cordicAngle(ca),
        .i_cordicX(ix), .i_cordicY(iy),
        .o_resValid(resv), .o_resCh(resch),
        .o_resX(resx), .o_resY(resy),
        .o_inFlight(infl)
    );

    // CORDIC stand-in: free-running delay line, no reset.
    logic [DW-1:0] mx [L];
    logic [DW-1:0] my [L];
    always @(posedge clk) begin
        for (int i = L-1; i > 0; i--) begin
            mx[i] <= mx[i-1];
            my[i] <= my[i-1];
        end
        mx[0] <= cx;
        my[0] <= cy;
    end
    assign ix = mx[L-1] + 16'd1;
    assign iy = my[L-1] - 16'd1;

    typedef struct {
        int          ch;
        logic [15:0] x;
        logic [15:0] y;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0] en;
        logic [3:0] vld;
        logic [3:0] rdy;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[21];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int res_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Result monitor.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (resv === 1'b1) begin
            res_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected result: got ch %0d x %0h, required none", resch, resx);
            end else begin
                e = sb.pop_front();
                chk("res ch", 64'(resch), 64'(e.ch));
                chk("res x", 64'(resx), 64'(e.x));
                chk("res y", 64'(resy), 64'(e.y));
                chk("res latency", 64'(cyc), 64'(e.cyc + 19));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int seq);
        for (int c = 0; c < N; c++) begin
            rx[c] = 16'(256*c + 16*seq + 3);
            ry[c] = 16'(16'h4000 - 256*c - 7*seq);
            ra[c] = 32'(c*32'h1000_0000 + seq*17 + 5);
        end
    endtask

    // Drive one cycle of enables/valids, check the grant, and after the edge
    // check the registered CORDIC inputs and queue the expected result.
    task automatic apply(input logic [3:0] e, input logic [3:0] v,
                         input logic [3:0] exp_rdy, input string tag);
        int ch;
        exp_t x;
        logic [31:0] ang;
        ch = -1;
        en = e;
        vld = v;
        #1;
        chk({tag, " ready"}, 64'(rdy), 64'(exp_rdy));
        for (int c = 0; c < N; c++) if (exp_rdy[c]) ch = c;
        ang = 32'd0;
        x = '{ch: 0, x: 16'd0, y: 16'd0, cyc: 0};
        if (ch >= 0) begin
            ang = ra[ch];
            x.ch = ch;
            x.x = rx[ch] + 16'd1;
            x.y = ry[ch] - 16'd1;
        end
        tick();
        chk({tag, " angle"}, 64'(ca), 64'(ang));
        if (ch >= 0) begin
            x.cyc = cyc;
            sb.push_back(x);
        end
    endtask

    initial begin
        int bad;
        int r0;
        en = '0; vld = '0; rx = '0; ry = '0; ra = '0;

        // Table: ptr wrap (3 -> 0), four-way rotation, ch2 disabled.
        tbl[0]  = '{4'b1111, 4'b1000, 4'b1000};
        tbl[1]  = '{4'b1111, 4'b1001, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b1001, 4'b1000};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b0010};
        tbl[5]  = '{4'b1111, 4'b1111, 4'b0100};
        tbl[6]  = '{4'b1111, 4'b1111, 4'b1000};
        tbl[7]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[8]  = '{4'b1111, 4'b1111, 4'b0010};
        tbl[9]  = '{4'b1111, 4'b1111, 4'b0100};
        tbl[10] = '{4'b1111, 4'b1111, 4'b1000};
        tbl[11] = '{4'b1111, 4'b1111, 4'b0001};
        tbl[12] = '{4'b1111, 4'b1111, 4'b0010};
        tbl[13] = '{4'b1111, 4'b1111, 4'b0100};
        tbl[14] = '{4'b1111, 4'b1111, 4'b1000};
        tbl[15] = '{4'b1011, 4'b1111, 4'b0001};
        tbl[16] = '{4'b1011, 4'b1111, 4'b0010};
        tbl[17] = '{4'b1011, 4'b1111, 4'b1000};
        tbl[18] = '{4'b1011, 4'b1111, 4'b0001};
        tbl[19] = '{4'b1011, 4'b1111, 4'b0010};
        tbl[20] = '{4'b1011, 4'b1111, 4'b1000};

        // Reset state; grant follows ptr=0 while held in reset.
        en = 4'b1111; vld = 4'b1010;
        #2;
        chk("rst ready", 64'(rdy), 64'(4'b0010));
        chk("rst angle", 64'(ca), 64'd0);
        chk("rst resValid", 64'(resv), 64'd0);
        chk("rst inFlight", 64'(infl), 64'd0);
        repeat (3) tick();
        chk("rst hold cordicX", 64'(cx), 64'd0);
        chk("rst hold inFlight", 64'(infl), 64'd0);
        vld = '0;
        rstn = 1'b1;

        // Single request on ch2.
        rx[2] = 16'h1000; ry[2] = 16'h0200; ra[2] = 32'h4000_0000;
        apply(4'b1111, 4'b0100, 4'b0100, "t1");
        vld = '0;
        chk("t1 inFlight", 64'(infl), 64'd1);
        bad = 0;
        for (int j = 1; j <= 18; j++) begin
            tick();
            if (resv !== 1'b0 || infl !== 7'd1) bad++;
        end
        chk("t1 quiet window", 64'(bad), 64'd0);
        tick();
        chk("t1 resValid", 64'(resv), 64'd1);
        chk("t1 resCh", 64'(resch), 64'd2);
        chk("t1 resX", 64'(resx), 64'h1001);
        chk("t1 resY", 64'(resy), 64'h01FF);
        chk("t1 inFlight after", 64'(infl), 64'd0);
        tick();
        chk("t1 strobe width", 64'(resv), 64'd0);
        chk("t1 resX hold", 64'(resx), 64'h1001);

        // Back-to-back table; in-flight climbs to 19 and stays there.
        for (int i = 0; i < 21; i++) begin
            set_data(i);
            apply(tbl[i].en, tbl[i].vld, tbl[i].rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d inFlight", i), 64'(infl), 64'((i + 1 < 19) ? i + 1 : 19));
        end
        vld = '0;
        repeat (22) tick();
        chk("tbl drained", 64'(sb.size()), 64'd0);
        chk("tbl inFlight 0", 64'(infl), 64'd0);

        // ch1 disabled after its request is in flight.
        set_data(30);
        apply(4'b1111, 4'b0010, 4'b0010, "t4");
        vld = '0;
        for (int j = 1; j <= 19; j++) begin
            tick();
            if (j == 5) begin
                en = 4'b1101;
                vld = 4'b0010;
                #1;
                chk("t4 disabled ready", 64'(rdy), 64'd0);
                vld = '0;
            end
        end
        chk("t4 resValid", 64'(resv), 64'd1);
        chk("t4 resCh", 64'(resch), 64'd1);
        en = 4'b1111;

        // Reset mid-flight.
        apply(4'b1111, 4'b1111, 4'b0100, "t5a");
        set_data(41);
        apply(4'b1111, 4'b1111, 4'b1000, "t5b");
        set_data(42);
        apply(4'b1111, 4'b1111, 4'b0001, "t5c");
        set_data(43);
        apply(4'b1111, 4'b1111, 4'b0010, "t5d");
        set_data(44);
        apply(4'b1111, 4'b1111, 4'b0100, "t5e");
        set_data(45);
        apply(4'b1111, 4'b1111, 4'b1000, "t5f");
        vld = '0;
        repeat (3) tick();
        chk("t5 pre inFlight", 64'(infl), 64'd6);
        rstn = 1'b0;
        vld = 4'b1111;
        #1;
        chk("t5 rst resX", 64'(resx), 64'd0);
        chk("t5 rst resY", 64'(resy), 64'd0);
        chk("t5 rst resCh", 64'(resch), 64'd0);
        chk("t5 rst resValid", 64'(resv), 64'd0);
        chk("t5 rst cordicY", 64'(cy), 64'd0);
        chk("t5 rst inFlight", 64'(infl), 64'd0);
        chk("t5 rst ready", 64'(rdy), 64'(4'b0001));
        sb.delete();
        repeat (2) tick();
        rstn = 1'b1;
        r0 = res_cnt;
        set_data(50);
        apply(4'b1111, 4'b1111, 4'b0001, "t5 post");
        vld = '0;
        repeat (30) tick();
        chk("t5 result count", 64'(res_cnt - r0), 64'd1);
        chk("t5 drained", 64'(sb.size()), 64'd0);
        chk("t5 inFlight end", 64'(infl), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
